fetch_unit: RTL and testbench

//  Instruction-fetch stage of the RV32 pipeline. Holds the PC and issues word

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_queue.sv | 62 ++++++
 rtl/fetch_unit.sv | 123 ++++++++++++
 tb/tb_fetch_unit.sv | 449 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Fetch stage shared types: queue entry, FSM state, NOP encoding.
// No ports; imported by fetch_queue and fetch_unit.
package fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        F_RUN,
        F_FLUSH
    } fetch_state_t;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

endpackage

// File: rtl/fetch_queue.sv
// DEPTH-entry sync FIFO of fetched {pc, instr} entries.
// Ports: clk, rst (async high), push/push_entry, pop, flush, count, head_valid, head.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH) + 1,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output logic [CW-1:0] count,
    output logic         head_valid,
    output fetch_entry_t head
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    fetch_entry_t    mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   cnt;
    logic            do_pop;
    logic            do_push;

    assign do_pop  = pop && (cnt != '0);
    // A full queue may still take a push when the head leaves this cycle.
    assign do_push = push && ((cnt != FULL) || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

    assign count      = cnt;
    assign head_valid = (cnt != '0);
    assign head       = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// RV32 instruction-fetch stage: PC, credit-limited imem requests, response
// queue to IF/ID, redirect flush with stale-response dropping.
// Ports: clk, rst, fetch_en, imem_req_*/imem_addr, imem_rsp_*,
//        redirect_valid/redirect_pc, if_valid/if_ready/if_instr/if_pc.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] CREDITS = (CW + 1)'(DEPTH);

    logic [31:0]   pc_q;
    logic [31:0]   resp_pc;
    logic [CW-1:0] in_flight;
    logic [CW-1:0] drop_cnt;
    fetch_state_t  state;

    logic [CW-1:0] q_count;
    logic          q_valid;
    fetch_entry_t  q_head;
    fetch_entry_t  q_entry;

    logic          req_fire;
    logic          dropping;
    logic          q_push;
    logic [CW:0]   used;
    logic [CW-1:0] redir_drop;
    logic [31:0]   redir_pc;
    logic          unused_pc_bits;

    assign unused_pc_bits = &redirect_pc[1:0];
    assign redir_pc = {redirect_pc[31:2], 2'b00};

    // Dropped responses stay in in_flight, so they still hold credit.
    assign used = {1'b0, q_count} + {1'b0, in_flight};

    assign imem_req_valid = !rst && fetch_en && !redirect_valid
                          && (used < CREDITS);
    assign imem_addr = pc_q;
    assign req_fire  = imem_req_valid && imem_req_ready;

    assign dropping   = (state == F_FLUSH);
    assign q_push     = imem_rsp_valid && !redirect_valid && !dropping;
    assign redir_drop = in_flight - CW'(imem_rsp_valid);
    assign q_entry    = '{pc: resp_pc, instr: imem_rsp_data};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            resp_pc   <= RESET_PC;
            in_flight <= '0;
            drop_cnt  <= '0;
            state     <= F_RUN;
        end else begin
            in_flight <= in_flight + CW'(req_fire) - CW'(imem_rsp_valid);
            if (redirect_valid) begin
                pc_q     <= redir_pc;
                resp_pc  <= redir_pc;
                drop_cnt <= redir_drop;
                state    <= (redir_drop != '0) ? F_FLUSH : F_RUN;
            end else begin
                if (req_fire) begin
                    pc_q <= pc_q + 32'd4;
                end
                if (imem_rsp_valid) begin
                    unique case (state)
                        F_FLUSH: begin
                            drop_cnt <= drop_cnt - CW'(1);
                            if (drop_cnt == CW'(1)) begin
                                state <= F_RUN;
                            end
                        end
                        F_RUN: begin
                            resp_pc <= resp_pc + 32'd4;
                        end
                    endcase
                end
            end
        end
    end

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk        (clk),
        .rst        (rst),
        .push       (q_push),
        .push_entry (q_entry),
        .pop        (q_valid && if_ready),
        .flush      (redirect_valid),
        .count      (q_count),
        .head_valid (q_valid),
        .head       (q_head)
    );

    assign if_valid = q_valid;
    assign if_instr = q_valid ? q_head.instr : INSTR_NOP;
    assign if_pc    = q_valid ? q_head.pc : RESET_PC;

    // The credit rule makes a response into a full queue impossible.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(imem_rsp_valid && (q_count == CW'(DEPTH))));
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order imem model.
// Ports: none.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_en = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int lat = 1;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t        pending[$];
    logic [31:0]  acc_log[$];
    fetch_entry_t cons_log[$];

    fetch_unit #(.RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    // Inputs are stable mid-cycle, so the upcoming edge's handshakes are seen here.
    always @(negedge clk) begin
        if (rst) begin
            pending.delete();
        end else begin
            if (imem_rsp_valid && pending.size() > 0)
                void'(pending.pop_front());
            if (imem_req_valid && imem_req_ready) begin
                pending.push_back('{imem_addr, cyc + 1 + lat});
                acc_log.push_back(imem_addr);
            end
            if (if_valid && if_ready && !redirect_valid)
                cons_log.push_back('{pc: if_pc, instr: if_instr});
        end
    end

    always @(posedge clk) begin
        cyc++;
        #1;
        if (!rst && pending.size() > 0 && pending[0].due <= cyc + 1) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = word(pending[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic drain();
        int k = 0;
        fetch_en = 1'b0;
        if_ready = 1'b1;
        while ((pending.size() != 0 || if_valid) && k < 60) begin
            step();
            k++;
        end
        step();
        n_cmp++;
        if (k >= 60) begin
            n_bad++;
            $display("FAIL drain_timeout: got %0d cycles want <60", k);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        run(2);
        @(negedge clk);
        n_cmp++;
        if (imem_req_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_req_valid: got %b want 0", imem_req_valid);
        end
        n_cmp++;
        if (imem_addr !== 32'h0) begin
            n_bad++;
            $display("FAIL rst_addr: got %h want 0", imem_addr);
        end
        n_cmp++;
        if (if_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_if_valid: got %b want 0", if_valid);
        end
        n_cmp++;
        if (if_instr !== INSTR_NOP) begin
            n_bad++;
            $display("FAIL rst_if_instr: got %h want %h", if_instr, INSTR_NOP);
        end
        n_cmp++;
        if (if_pc !== 32'h0) begin
            n_bad++;
            $display("FAIL rst_if_pc: got %h want 0", if_pc);
        end
    endtask

    task automatic test_first_fetch();
        int k = 0;
        fetch_en = 1'b1;
        if_ready = 1'b1;
        lat = 1;
        imem_req_ready = 1'b1;
        step();
        rst = 1'b0;
        do begin
            @(negedge clk);
            k++;
        end while (!imem_rsp_valid && k < 20);
        n_cmp++;
        if (!imem_rsp_valid) begin
            n_bad++;
            $display("FAIL first_rsp_timeout: got none want rsp");
        end
        n_cmp++;
        if (if_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL no_bypass: got if_valid %b want 0", if_valid);
        end
        @(negedge clk);
        n_cmp++;
        if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== word(0)) begin
            n_bad++;
            $display("FAIL first_if: got v%b pc %h i %h want v1 pc 0 i %h",
                     if_valid, if_pc, if_instr, word(0));
        end
        run(12);
        n_cmp++;
        if (acc_log.size() < 4) begin
            n_bad++;
            $display("FAIL addr_count: got %0d want >=4", acc_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (acc_log[i] !== 32'(i * 4)) begin
                    n_bad++;
                    $display("FAIL addr_seq[%0d]: got %h want %h",
                             i, acc_log[i], 32'(i * 4));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int outstanding;
        if_ready = 1'b0;
        repeat (10) begin
            step();
            @(negedge clk);
            outstanding = acc_log.size() - cons_log.size();
            n_cmp++;
            if (outstanding > DEPTH) begin
                n_bad++;
                $display("FAIL credit: got %0d outstanding want <=%0d",
                         outstanding, DEPTH);
            end
        end
        n_cmp++;
        if (imem_req_valid !== 1'b0 || if_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL stall: got req %b ifv %b want req 0 ifv 1",
                     imem_req_valid, if_valid);
        end
        if_ready = 1'b1;
        run(20);
        n_cmp++;
        if (cons_log.size() < 8) begin
            n_bad++;
            $display("FAIL drain_count: got %0d want >=8", cons_log.size());
        end
        for (int i = 0; i < cons_log.size(); i++) begin
            n_cmp++;
            if (cons_log[i].pc !== 32'(i * 4)
                || cons_log[i].instr !== word(32'(i * 4))) begin
                n_bad++;
                $display("FAIL drain_order[%0d]: got %h/%h want %h/%h", i,
                         cons_log[i].pc, cons_log[i].instr,
                         32'(i * 4), word(32'(i * 4)));
            end
        end
    endtask

    task automatic test_redirect_inflight();
        int k = 0;
        int mark;
        logic [31:0] a0;
        logic [31:0] a1;
        drain();
        redirect_valid = 1'b1;
        redirect_pc = 32'h10;
        step();
        redirect_valid = 1'b0;
        lat = 4;
        fetch_en = 1'b1;
        mark = acc_log.size();
        do begin
            @(negedge clk);
            k++;
        end while (pending.size() < 2 && k < 20);
        a0 = (acc_log.size() > mark) ? acc_log[mark] : 32'hx;
        a1 = (acc_log.size() > mark + 1) ? acc_log[mark + 1] : 32'hx;
        n_cmp++;
        if (a0 !== 32'h10 || a1 !== 32'h14) begin
            n_bad++;
            $display("FAIL pre_redirect_addrs: got %h %h want 10 14", a0, a1);
        end
        step();
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        cons_log.delete();
        mark = acc_log.size();
        @(negedge clk);
        n_cmp++;
        if (imem_req_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL redirect_no_req: got %b want 0", imem_req_valid);
        end
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (if_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL redirect_if_valid: got %b want 0", if_valid);
        end
        run(30);
        a0 = (cons_log.size() > 0) ? cons_log[0].pc : 32'hx;
        a1 = (cons_log.size() > 0) ? cons_log[0].instr : 32'hx;
        n_cmp++;
        if (a0 !== 32'h100 || a1 !== word(32'h100)) begin
            n_bad++;
            $display("FAIL redirect_first_if: got %h/%h want 100/%h",
                     a0, a1, word(32'h100));
        end
        a0 = (acc_log.size() > mark) ? acc_log[mark] : 32'hx;
        a1 = (acc_log.size() > mark + 1) ? acc_log[mark + 1] : 32'hx;
        n_cmp++;
        if (a0 !== 32'h100 || a1 !== 32'h104) begin
            n_bad++;
            $display("FAIL redirect_addrs: got %h %h want 100 104", a0, a1);
        end
    endtask

    task automatic test_redirect_with_rsp();
        int mark;
        logic [31:0] g_pc;
        logic [31:0] g_in;
        drain();
        lat = 2;
        imem_req_ready = 1'b1;
        fetch_en = 1'b1;
        step();
        imem_req_ready = 1'b0;
        step();
        redirect_valid = 1'b1;
        redirect_pc = 32'h400;
        cons_log.delete();
        mark = acc_log.size();
        @(negedge clk);
        n_cmp++;
        if (imem_rsp_valid !== 1'b1 || imem_req_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL redir_rsp_cycle: got rsp %b req %b want 1 0",
                     imem_rsp_valid, imem_req_valid);
        end
        step();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        run(15);
        g_pc = (cons_log.size() > 0) ? cons_log[0].pc : 32'hx;
        g_in = (cons_log.size() > 0) ? cons_log[0].instr : 32'hx;
        n_cmp++;
        if (g_pc !== 32'h400 || g_in !== word(32'h400)) begin
            n_bad++;
            $display("FAIL redir_rsp_first_if: got %h/%h want 400/%h",
                     g_pc, g_in, word(32'h400));
        end
        g_pc = (acc_log.size() > mark) ? acc_log[mark] : 32'hx;
        n_cmp++;
        if (g_pc !== 32'h400) begin
            n_bad++;
            $display("FAIL redir_rsp_addr: got %h want 400", g_pc);
        end
    endtask

    task automatic test_back_to_back();
        lat = 3;
        fetch_en = 1'b1;
        if_ready = 1'b1;
        run(6);
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        cons_log.delete();
        step();
        redirect_valid = 1'b0;
        step();
        redirect_valid = 1'b1;
        redirect_pc = 32'h300;
        step();
        redirect_valid = 1'b0;
        run(40);
        n_cmp++;
        if (cons_log.size() < 3) begin
            n_bad++;
            $display("FAIL b2b_count: got %0d want >=3", cons_log.size());
        end
        for (int i = 0; i < cons_log.size(); i++) begin
            n_cmp++;
            if (cons_log[i].pc !== 32'h300 + 32'(i * 4)
                || cons_log[i].instr !== word(32'h300 + 32'(i * 4))) begin
                n_bad++;
                $display("FAIL b2b_seq[%0d]: got %h/%h want %h", i,
                         cons_log[i].pc, cons_log[i].instr,
                         32'h300 + 32'(i * 4));
            end
        end
    endtask

    task automatic test_reset_midstream();
        int mark;
        logic [31:0] g;
        lat = 1;
        fetch_en = 1'b1;
        if_ready = 1'b0;
        run(10);
        @(negedge clk);
        n_cmp++;
        if (if_valid !== 1'b1 || imem_req_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL full_before_rst: got ifv %b req %b want 1 0",
                     if_valid, imem_req_valid);
        end
        step();
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (imem_req_valid !== 1'b0 || imem_addr !== 32'h0
            || if_valid !== 1'b0 || if_instr !== INSTR_NOP
            || if_pc !== 32'h0) begin
            n_bad++;
            $display("FAIL async_rst: got %b %h %b %h %h want 0 0 0 %h 0",
                     imem_req_valid, imem_addr, if_valid, if_instr, if_pc,
                     INSTR_NOP);
        end
        step();
        step();
        acc_log.delete();
        cons_log.delete();
        if_ready = 1'b1;
        rst = 1'b0;
        run(10);
        g = (acc_log.size() > 0) ? acc_log[0] : 32'hx;
        n_cmp++;
        if (g !== 32'h0) begin
            n_bad++;
            $display("FAIL restart_addr: got %h want 0", g);
        end
        g = (cons_log.size() > 0) ? cons_log[0].pc : 32'hx;
        n_cmp++;
        if (g !== 32'h0) begin
            n_bad++;
            $display("FAIL restart_if_pc: got %h want 0", g);
        end
        redirect_valid = 1'b1;
        redirect_pc = 32'h203;
        cons_log.delete();
        mark = acc_log.size();
        step();
        redirect_valid = 1'b0;
        run(15);
        g = (acc_log.size() > mark) ? acc_log[mark] : 32'hx;
        n_cmp++;
        if (g !== 32'h200) begin
            n_bad++;
            $display("FAIL align_addr: got %h want 200", g);
        end
        g = (cons_log.size() > 0) ? cons_log[0].pc : 32'hx;
        n_cmp++;
        if (g !== 32'h200) begin
            n_bad++;
            $display("FAIL align_if_pc: got %h want 200", g);
        end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_backpressure();
        test_redirect_inflight();
        test_redirect_with_rsp();
        test_back_to_back();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
